// File: rtl/queue_pop_packer_pkg.sv
// Shared types and defaults for the queue pop-side packer.
// Lane-count width helper keeps counters sized to p_pack+1 states.
package op_centric_queues_v1_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    localparam int P_BITWIDTH_DEF = 32;
    localparam int P_PACK_DEF     = 4;
    localparam int P_TIMEOUT_DEF  = 16;

    function automatic int cnt_width(input int pack);
        return $clog2(pack + 1);
    endfunction

    typedef logic [$clog2(P_PACK_DEF+1)-1:0] cnt_def_t;

endpackage

// File: rtl/queue_pop_packer_if.sv
// Pop-front and wide-beat handshake bundle for queue_pop_packer.
// master = packer side, slave = queue/sink side.
interface queue_pop_packer_if #(
    parameter int p_bitwidth = 32,
    parameter int p_pack     = 4
);
    logic                         pop_front_en;
    logic                         pop_front_rdy;
    logic [p_bitwidth-1:0]        pop_front_data;
    logic                         flush;
    logic                         out_val;
    logic                         out_rdy;
    logic [p_pack*p_bitwidth-1:0] out_data;
    logic [p_pack-1:0]            out_keep;

    modport master (
        output pop_front_en, out_val, out_data, out_keep,
        input  pop_front_rdy, pop_front_data, flush, out_rdy
    );

    modport slave (
        input  pop_front_en, out_val, out_data, out_keep,
        output pop_front_rdy, pop_front_data, flush, out_rdy
    );
endinterface

// File: rtl/queue_pop_packer_lanes.sv
// p_pack-lane register array; a written lane sets its keep bit.
// clr_i zeroes all lanes and keep bits so unfilled lanes read 0.
module v1_PackLaneRegs #(
    parameter int W  = 32,
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic            clk,
    input  logic            clr_i,
    input  logic            we_i,
    input  logic [IW-1:0]   idx_i,
    input  logic [W-1:0]    data_i,
    output logic [N*W-1:0]  lanes_o,
    output logic [N-1:0]    keep_o
);
    logic [N-1:0][W-1:0] lane_q;
    logic [N-1:0]        keep_q;

    always_ff @(posedge clk) begin
        if (clr_i) begin
            lane_q <= '0;
            keep_q <= '0;
        end else if (we_i) begin
            lane_q[idx_i] <= data_i;
            keep_q[idx_i] <= 1'b1;
        end
    end

    assign lanes_o = lane_q;
    assign keep_o  = keep_q;
endmodule

// File: rtl/queue_pop_packer.sv
// Packs p_pack queue entries into one wide valid/ready beat; flush emits partials.
// Optional PACKER_TIMEOUT_EN: auto-flush after p_timeout idle FILL cycles.
module queue_pop_packer
    import op_centric_queues_v1_pkg::*;
#(
    parameter int p_bitwidth = P_BITWIDTH_DEF,
    parameter int p_pack     = P_PACK_DEF,
    parameter int p_timeout  = P_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    queue_pop_packer_if.master bus
);
    localparam int CW = cnt_width(p_pack);
    localparam int IW = (p_pack > 1) ? $clog2(p_pack) : 1;
    localparam logic [CW-1:0] LAST = CW'(p_pack - 1);

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic                val_q;
    logic [p_pack-1:0]   keep_q;
    logic                pop;
    logic                fl;
    logic                go_drain;
    logic                hs;
    logic                clr;
    logic                tmo_fire;
    logic [p_pack-1:0]   lane_keep;
    logic [p_pack-1:0]   pop_bit;

    assign pop      = (state_q == FILL) && bus.pop_front_rdy;
    assign fl       = bus.flush || tmo_fire;
    assign pop_bit  = pop ? (p_pack'(1) << cnt_q) : '0;
    assign go_drain = (pop && (cnt_q == LAST))
                   || (fl && ((cnt_q != '0) || pop));
    assign hs       = val_q && bus.out_rdy;
    assign clr      = !rst || hs;

`ifdef PACKER_TIMEOUT_EN
    localparam int TW = $clog2(p_timeout + 1);
    localparam logic [TW-1:0] TLAST = TW'(p_timeout - 1);

    logic [TW-1:0] tmo_q;
    logic          idle;

    assign idle     = (state_q == FILL) && (cnt_q != '0) && !pop;
    assign tmo_fire = idle && (tmo_q == TLAST);

    always_ff @(posedge clk) begin
        if (!rst)
            tmo_q <= '0;
        else if (idle && !tmo_fire)
            tmo_q <= tmo_q + 1'b1;
        else
            tmo_q <= '0;
    end
`else
    assign tmo_fire = 1'b0;
`endif

    // Keep is latched on DRAIN entry, folding in a same-cycle pop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            val_q   <= 1'b0;
            keep_q  <= '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (go_drain) begin
                        state_q <= DRAIN;
                        cnt_q   <= '0;
                        val_q   <= 1'b1;
                        keep_q  <= lane_keep | pop_bit;
                    end else if (pop) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (bus.out_rdy) begin
                        state_q <= FILL;
                        val_q   <= 1'b0;
                        keep_q  <= '0;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    v1_PackLaneRegs #(
        .W  (p_bitwidth),
        .N  (p_pack),
        .IW (IW)
    ) u_lanes (
        .clk     (clk),
        .clr_i   (clr),
        .we_i    (pop),
        .idx_i   (cnt_q[IW-1:0]),
        .data_i  (bus.pop_front_data),
        .lanes_o (bus.out_data),
        .keep_o  (lane_keep)
    );

    assign bus.pop_front_en = pop;
    assign bus.out_val      = val_q;
    assign bus.out_keep     = keep_q;
endmodule

// File: tb/tb_queue_pop_packer.sv
// Directed bench for queue_pop_packer with a small queue model on pop_front.
module tb_queue_pop_packer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    queue_pop_packer_if #(.p_bitwidth(32), .p_pack(4)) bus();

    queue_pop_packer #(
        .p_bitwidth(32),
        .p_pack(4),
        .p_timeout(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic drive();
        bus.pop_front_rdy  = (q.size() > 0);
        bus.pop_front_data = (q.size() > 0) ? q[0] : 32'h0;
    endtask

    task automatic push(input logic [31:0] d);
        q.push_back(d);
        drive();
    endtask

    task automatic cyc();
        logic f;
        @(negedge clk);
        f = bus.pop_front_en && bus.pop_front_rdy;
        @(posedge clk);
        #1;
        if (f) void'(q.pop_front());
        drive();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        checks++;
        if (bus.out_val !== 1'b0) begin
            errors++; $display("FAIL reset_val got %0b exp 0", bus.out_val);
        end
        checks++;
        if (bus.out_keep !== 4'b0000) begin
            errors++; $display("FAIL reset_keep got %b exp 0000", bus.out_keep);
        end
        checks++;
        if (bus.out_data !== 128'h0) begin
            errors++; $display("FAIL reset_data got %h exp 0", bus.out_data);
        end
        checks++;
        if (bus.pop_front_en !== 1'b0) begin
            errors++; $display("FAIL reset_en got %0b exp 0", bus.pop_front_en);
        end
    endtask

    task automatic test_full_pack();
        bus.out_rdy = 1'b1;
        for (int i = 1; i <= 4; i++) push(32'(i));
        for (int i = 0; i < 3; i++) cyc();
        checks++;
        if (bus.out_val !== 1'b0) begin
            errors++; $display("FAIL full_early_val got %0b exp 0", bus.out_val);
        end
        cyc();
        checks++;
        if (bus.out_val !== 1'b1) begin
            errors++; $display("FAIL full_val got %0b exp 1", bus.out_val);
        end
        checks++;
        if (bus.out_data !== 128'h00000004_00000003_00000002_00000001) begin
            errors++; $display("FAIL full_data got %h exp 4_3_2_1", bus.out_data);
        end
        checks++;
        if (bus.out_keep !== 4'b1111) begin
            errors++; $display("FAIL full_keep got %b exp 1111", bus.out_keep);
        end
        checks++;
        if (bus.pop_front_en !== 1'b0) begin
            errors++; $display("FAIL full_en got %0b exp 0", bus.pop_front_en);
        end
        cyc();
        checks++;
        if (bus.out_val !== 1'b0 || bus.out_data !== 128'h0) begin
            errors++; $display("FAIL full_after got val %0b data %h exp 0 0", bus.out_val, bus.out_data);
        end
    endtask

    task automatic test_backpressure();
        bus.out_rdy = 1'b0;
        for (int i = 5; i <= 9; i++) push(32'(i));
        for (int i = 0; i < 4; i++) cyc();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.out_val !== 1'b1 || bus.pop_front_en !== 1'b0
                || bus.out_data !== 128'h00000008_00000007_00000006_00000005
                || bus.out_keep !== 4'b1111 || q.size() != 1) begin
                errors++;
                $display("FAIL bp_hold[%0d] got val %0b en %0b data %h keep %b q %0d exp 1 0 8_7_6_5 1111 1",
                         i, bus.out_val, bus.pop_front_en, bus.out_data, bus.out_keep, q.size());
            end
            cyc();
        end
        bus.out_rdy = 1'b1;
        cyc();
        checks++;
        if (bus.out_val !== 1'b0 || q.size() != 1) begin
            errors++; $display("FAIL bp_hs got val %0b q %0d exp 0 1", bus.out_val, q.size());
        end
        cyc();
        checks++;
        if (q.size() != 0) begin
            errors++; $display("FAIL bp_pop9 got q %0d exp 0", q.size());
        end
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        checks++;
        if (bus.out_keep !== 4'b0001 || bus.out_data !== 128'h9) begin
            errors++; $display("FAIL bp_tail got keep %b data %h exp 0001 9", bus.out_keep, bus.out_data);
        end
        cyc();
    endtask

    task automatic test_reset_mid_drain();
        bus.out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h11 + 32'(i));
        for (int i = 0; i < 4; i++) cyc();
        checks++;
        if (bus.out_val !== 1'b1) begin
            errors++; $display("FAIL rmd_pending got %0b exp 1", bus.out_val);
        end
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        checks++;
        if (bus.out_val !== 1'b0 || bus.out_keep !== 4'b0000 || bus.out_data !== 128'h0) begin
            errors++; $display("FAIL rmd_cleared got val %0b keep %b data %h exp 0 0000 0",
                               bus.out_val, bus.out_keep, bus.out_data);
        end
        push(32'h77);
        cyc();
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        checks++;
        if (bus.out_keep !== 4'b0001 || bus.out_data !== 128'h77) begin
            errors++; $display("FAIL rmd_lane0 got keep %b data %h exp 0001 77", bus.out_keep, bus.out_data);
        end
        bus.out_rdy = 1'b1;
        cyc();
    endtask

    task automatic test_partial_flush();
        bus.out_rdy = 1'b0;
        push(32'hA);
        push(32'hB);
        cyc();
        cyc();
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        checks++;
        if (bus.out_val !== 1'b1 || bus.out_keep !== 4'b0011
            || bus.out_data !== 128'h00000000_00000000_0000000B_0000000A) begin
            errors++; $display("FAIL pflush got val %0b keep %b data %h exp 1 0011 0_0_B_A",
                               bus.out_val, bus.out_keep, bus.out_data);
        end
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        checks++;
        if (bus.out_keep !== 4'b0011) begin
            errors++; $display("FAIL pflush_drain_ign got keep %b exp 0011", bus.out_keep);
        end
        bus.out_rdy = 1'b1;
        cyc();
    endtask

    task automatic test_flush_with_pop();
        bus.out_rdy = 1'b0;
        push(32'hD1);
        push(32'hD2);
        cyc();
        cyc();
        push(32'hC);
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        checks++;
        if (bus.out_keep !== 4'b0111
            || bus.out_data !== 128'h00000000_0000000C_000000D2_000000D1) begin
            errors++; $display("FAIL fpop got keep %b data %h exp 0111 0_C_D2_D1", bus.out_keep, bus.out_data);
        end
        bus.out_rdy = 1'b1;
        cyc();
        bus.flush = 1'b1;
        for (int i = 0; i < 3; i++) cyc();
        bus.flush = 1'b0;
        checks++;
        if (bus.out_val !== 1'b0) begin
            errors++; $display("FAIL fempty got val %0b exp 0", bus.out_val);
        end
        push(32'h33);
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        checks++;
        if (bus.out_keep !== 4'b0001 || bus.out_data !== 128'h33) begin
            errors++; $display("FAIL fcnt0_pop got keep %b data %h exp 0001 33", bus.out_keep, bus.out_data);
        end
        cyc();
        for (int i = 0; i < 3; i++) push(32'hE0 + 32'(i));
        cyc();
        cyc();
        cyc();
        push(32'hE3);
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        checks++;
        if (bus.out_keep !== 4'b1111
            || bus.out_data !== 128'h000000E3_000000E2_000000E1_000000E0) begin
            errors++; $display("FAIL flast got keep %b data %h exp 1111 E3_E2_E1_E0", bus.out_keep, bus.out_data);
        end
        cyc();
    endtask

    task automatic test_timeout();
        int seen;
        bus.out_rdy = 1'b0;
        push(32'h5);
        cyc();
`ifdef PACKER_TIMEOUT_EN
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            cyc();
            if (bus.out_val === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL tmo_early got %0d beats exp 0", seen);
        end
        cyc();
        checks++;
        if (bus.out_val !== 1'b1 || bus.out_keep !== 4'b0001 || bus.out_data !== 128'h5) begin
            errors++; $display("FAIL tmo_fire got val %0b keep %b data %h exp 1 0001 5",
                               bus.out_val, bus.out_keep, bus.out_data);
        end
`else
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (bus.out_val === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL tmo_off got %0d beat cycles exp 0", seen);
        end
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        checks++;
        if (bus.out_keep !== 4'b0001 || bus.out_data !== 128'h5) begin
            errors++; $display("FAIL tmo_off_flush got keep %b data %h exp 0001 5", bus.out_keep, bus.out_data);
        end
`endif
        bus.out_rdy = 1'b1;
        cyc();
    endtask

    initial begin
        bus.flush   = 1'b0;
        bus.out_rdy = 1'b0;
        drive();
        test_reset();
        test_full_pack();
        test_backpressure();
        test_reset_mid_drain();
        test_partial_flush();
        test_flush_with_pop();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/queue_pop_packer.md
Name: queue_pop_packer

Overview:
Downstream consumer of the op-centric queue's pop_front interface. Drains narrow entries one per cycle and packs p_pack consecutive entries into one wide beat. Presents each beat on a valid/ready output toward the wide sink (memory writer / NoC injector). A flush input emits partially filled beats with a lane-keep mask.

Parameters:
p_bitwidth, 32, width of one queue entry (must equal the queue's p_bitwidth)
p_pack, 4, entries per output beat (>=2)
p_timeout, 16, idle cycles before auto-flush (used only with PACKER_TIMEOUT_EN)

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk)
pop_front_en  output  1  pop command to queue; pop occurs when en && rdy
pop_front_rdy  input  1  queue non-empty; front entry valid
pop_front_data  input  p_bitwidth  queue front entry, valid while rdy=1
flush  input  1  level request: close current partial beat
out_val  output  1  wide beat valid
out_rdy  input  1  sink ready
out_data  output  p_pack*p_bitwidth  packed beat; lane i = bits [i*p_bitwidth +: p_bitwidth]
out_keep  output  p_pack  lane i holds a real entry

Behaviour:
- Reset (rst=0 at posedge): state=FILL, lane count=0, out_val=0, out_keep=0, out_data=0; timeout counter=0. Takes priority over all other events, including a mid-beat DRAIN (beat discarded).
- Two states: FILL, DRAIN.
- FILL: pop_front_en = pop_front_rdy (combinational; no pop issued on empty). out_val=0.
  - On pop: pop_front_data written to lane[count]; count++. The first popped entry goes to lane 0 (lowest bits).
  - Pop with count==p_pack-1: next state DRAIN, out_keep=all ones, count reset to 0.
  - flush=1 with count>0: next state DRAIN, out_keep = lanes filled, including any lane written by a same-cycle pop. A pop that fills the last lane on the same cycle gives keep=all ones.
  - flush=1 with count==0 and no pop: ignored.
  - flush=1 with count==0 and a pop: DRAIN with keep=0...01.
- DRAIN: pop_front_en=0. out_val=1; out_data and out_keep stable until handshake.
  - out_val && out_rdy: next state FILL, count=0, out_keep cleared.
  - flush in DRAIN: ignored; no effect on the next beat.
- Unfilled lanes of out_data are 0; lanes are cleared on entering FILL.
- Latency: last entry popped in cycle N -> out_val=1 in cycle N+1.
- Throughput: at most one beat per p_pack+1 cycles (no FILL/DRAIN overlap).
- out_val never drops without a handshake; out_data and out_keep do not change while out_val && !out_rdy.
- Count width: $clog2(p_pack+1).

Optional Feature:
PACKER_TIMEOUT_EN
- Defined: counter increments each FILL cycle with count>0 and no pop. It resets on any pop, on entering DRAIN, and on reset. At p_timeout it acts as an internal flush (same rules as flush).
- Undefined: no counter; p_timeout unused; partial beats leave only via flush.

Decomposition:
- Package op_centric_queues_v1_pkg: state enum (FILL, DRAIN), default p_pack/p_bitwidth constants, lane-count typedef helper.
- One natural sub-module: v1_PackLaneRegs, the p_pack-lane register array. Inputs: write-enable, lane index, data, clear. Outputs: concatenated lanes and keep mask.
- The FSM and counters stay in queue_pop_packer.

Test Plan:
- Reset mid-DRAIN: beat pending with out_rdy=0, assert rst=0 for one cycle -> out_val=0, out_keep=0 next cycle; subsequent pops land in lane 0.
- Full pack: queue holds 1,2,3,4, out_rdy=1 -> pops on 4 consecutive cycles; next cycle out_val=1, out_data=0x00000004_00000003_00000002_00000001, out_keep=4'b1111; then FILL.
- Backpressure: beat 5..8 pending, out_rdy=0 for 10 cycles -> pop_front_en=0, out_data/out_keep stable; queue entry 9 not popped until the cycle after handshake.
- Partial flush: pop 0xA, 0xB, then flush=1 with queue empty -> out_keep=4'b0011, lanes 2-3 = 0.
- Flush with same-cycle pop: count=2, flush=1 while popping 0xC -> keep=4'b0111, lane 2=0xC. Separately, count=0, empty queue, flush=1 -> no beat produced.
- Timeout (macro on, p_timeout=16): pop one entry 0x5 then queue empty -> out_val=1 after 16 idle cycles with keep=4'b0001. With macro off -> no beat after 100 cycles.
